// File: rtl/lsu_rmw.sv
// Load/store unit between the core and a word-wide data memory.
// Loads extract and extend a byte/half/word lane; SB/SH use read-modify-write
// because dmem only accepts whole-word writes. Bad accesses get an error response.
module lsu_rmw #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {StIdle, StLoad, StMerge, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, merged_q, rdata_q;
  logic [2:0]  funct3_q;
  logic        err_q;

  logic        accept;
  logic        f3_bad, misal, oor, req_err;
  logic [4:0]  lane_sh;
  logic [31:0] shifted, load_ext, merged;

  assign accept = req_valid && (state_q == StIdle);

  // Decode the incoming request for illegal funct3, misalignment and range.
  always_comb begin
    f3_bad = 1'b0;
    misal  = 1'b0;
    if (req_we) begin
      f3_bad = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
    end else begin
      f3_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end
    case (req_funct3[1:0])
      2'b01:   misal = req_addr[0];
      2'b10:   misal = |req_addr[1:0];
      default: misal = 1'b0;
    endcase
    oor     = {2'b00, req_addr[31:2]} >= DEPTH;
    req_err = f3_bad || misal || oor;
  end

  // Load lane extraction/extension and store lane merge from the fetched word.
  always_comb begin
    lane_sh = {addr_q[1:0], 3'b000};
    shifted = mem_rd >> lane_sh;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'b0, shifted[7:0]};
      3'b101:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = mem_rd;
    endcase
    merged = mem_rd;
    if (funct3_q[1:0] == 2'b00) begin
      merged[lane_sh +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_err)                      state_d = StResp;
          else if (!req_we)                 state_d = StLoad;
          else if (req_funct3[1:0] == 2'b10) state_d = StWrite;
          else                              state_d = StMerge;
        end
      end
      StLoad:  state_d = StResp;
      StMerge: state_d = StWrite;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; rdata only changes on the edge entering RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      err_q    <= 1'b0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        err_q    <= req_err;
        if (req_err) rdata_q <= '0;
      end
      if (state_q == StLoad)  rdata_q  <= load_ext;
      if (state_q == StMerge) merged_q <= merged;
      if (state_q == StWrite) rdata_q  <= '0;
    end
  end

  // Outputs decoded from state; the async reset clears state so mem_we drops at once.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_err   = (state_q == StResp) && err_q;
    resp_rdata = rdata_q;
    mem_a      = '0;
    mem_wd     = '0;
    mem_we     = 1'b0;
    if (state_q == StLoad || state_q == StMerge || state_q == StWrite) begin
      mem_a = {addr_q[31:2], 2'b00};
    end
    if (state_q == StWrite) begin
      mem_we = 1'b1;
      mem_wd = (funct3_q[1:0] == 2'b10) ? wdata_q : merged_q;
    end
  end

endmodule
